// File: rtl/multicycle_controller.sv
// Main control FSM for the RV32I multicycle datapath: sequences fetch, decode,
// execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               zero,
   output logic               pcwrite,
   output logic               adrsrc,
   output logic               memwrite,
   output logic               irwrite,
   output logic [1:0]         resultsrc,
   output logic [1:0]         alusrca,
   output logic [1:0]         alusrcb,
   output logic               regwrite,
   output logic [1:0]         immsrc,
   output logic [2:0]         alucontrol,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t     state_q, state_d;
   logic [1:0] aluop;
   logic       pcupdate;
   logic       branch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign state_dbg = STATE_W'(state_q);

   // Next state and Moore outputs; codes 11-15 fall to the default and
   // recover to FETCH with every output low.
   always_comb begin
      state_d   = S_FETCH;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      regwrite  = 1'b0;
      aluop     = 2'b00;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            state_d   = S_DECODE;
            irwrite   = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            pcupdate  = 1'b1;
         end
         S_DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_JAL:       state_d = S_JAL;
               OP_BEQ:       state_d = S_BEQ;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            alusrca = 2'b10;
            alusrcb = 2'b01;
         end
         S_MEMREAD: begin
            state_d   = S_MEMWB;
            resultsrc = 2'b00;
            adrsrc    = 1'b1;
         end
         S_MEMWB: begin
            state_d   = S_FETCH;
            resultsrc = 2'b01;
            regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            state_d  = S_FETCH;
            adrsrc   = 1'b1;
            memwrite = 1'b1;
         end
         S_EXECUTER: begin
            state_d = S_ALUWB;
            alusrca = 2'b10;
            alusrcb = 2'b00;
            aluop   = 2'b10;
         end
         S_EXECUTEI: begin
            state_d = S_ALUWB;
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluop   = 2'b10;
         end
         S_ALUWB: begin
            state_d  = S_FETCH;
            regwrite = 1'b1;
         end
         S_JAL: begin
            state_d  = S_ALUWB;
            alusrca  = 2'b01;
            alusrcb  = 2'b10;
            pcupdate = 1'b1;
         end
         S_BEQ: begin
            state_d = S_FETCH;
            alusrca = 2'b10;
            alusrcb = 2'b00;
            aluop   = 2'b01;
            branch  = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign pcwrite = pcupdate | (branch & zero);

   always_comb begin
      immsrc = 2'b00;
      case (op)
         OP_SW:   immsrc = 2'b01;
         OP_BEQ:  immsrc = 2'b10;
         OP_JAL:  immsrc = 2'b11;
         default: immsrc = 2'b00;
      endcase
   end

   // Only register-register forms can request sub; addi shares funct3=000.
   always_comb begin
      alucontrol = 3'b000;
      case (aluop)
         2'b00: alucontrol = 3'b000;
         2'b01: alucontrol = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alucontrol = 3'b101;
               3'b110:  alucontrol = 3'b011;
               3'b111:  alucontrol = 3'b010;
               default: alucontrol = 3'b000;
            endcase
         end
         default: alucontrol = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction words, mid-instruction
// reset and random instructions checked against an instruction-level model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .regwrite(regwrite), .immsrc(immsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IA = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  function automatic bit is_legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IA) || (o == JL) || (o == BQ);
  endfunction

  // Visited states for one instruction, from FETCH up to (not including) the next FETCH.
  function automatic void state_path(input logic [6:0] o, output int path[$]);
    path = {};
    path.push_back(0);
    path.push_back(1);
    if (o == LW)      path = {path, 2, 3, 4};
    else if (o == SW) path = {path, 2, 5};
    else if (o == RT) path = {path, 6, 7};
    else if (o == IA) path = {path, 8, 7};
    else if (o == JL) path = {path, 9, 7};
    else if (o == BQ) path.push_back(10);
  endfunction

  // ALU operation an instruction asks for in its execute step.
  function automatic logic [2:0] exec_op(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Packed {pcwrite,adrsrc,memwrite,irwrite,resultsrc,alusrca,alusrcb,regwrite,immsrc,alucontrol,illegal}
  function automatic logic [16:0] expect_outs(input int st, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 3'b000;
    imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    case (st)
      0:  begin irw = 1; pcw = 1; sb = 2; res = 2; end
      1:  begin sa = 1; sb = 1; ill = !is_legal(o); end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin res = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; sb = 0; alu = exec_op(o, f3, f7); end
      7:  rw = 1;
      8:  begin sa = 2; sb = 1; alu = exec_op(o, f3, f7); end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'b001; pcw = z; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, res, sa, sb, rw, imm, alu, ill};
  endfunction

  function automatic logic [16:0] dut_outs();
    return {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
            regwrite, immsrc, alucontrol, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Entered just after a rising edge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    int path[$];
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    state_path(o, path);
    foreach (path[i]) begin
      @(negedge clk);
      check($sformatf("%s_state%0d", name, i), 32'(state_dbg), 32'(path[i]));
      check($sformatf("%s_outs%0d", name, i), 32'(dut_outs()),
            32'(expect_outs(path[i], o, f3, f7, z)));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_word(input string name, input logic [31:0] w, input logic z);
    run_instr(name, w[6:0], w[14:12], w[30], z);
  endtask

  initial begin
    logic [6:0] rop;
    int kind;
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_outs", 32'(dut_outs()), 32'(expect_outs(0, 7'd0, 3'd0, 1'b0, 1'b0)));
    @(posedge clk); #1; reset = 1'b0;

    run_word("lw", 32'h00402083, 1'b0);
    run_word("sw", 32'h00102223, 1'b1);
    run_word("sub", 32'h402081B3, 1'b0);
    run_instr("addi", IA, 3'b000, 1'b1, 1'b0);
    run_word("beq_t", 32'h00208463, 1'b1);
    run_word("beq_nt", 32'h00208463, 1'b0);
    run_word("jal", 32'h008000EF, 1'b0);
    run_instr("illegal", 7'b0000000, 3'b000, 1'b0, 1'b1);

    // Reset arriving mid-MEMREAD must take effect before the next edge.
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_reset_memread", 32'(state_dbg), 32'd3);
    reset = 1'b1; #1;
    check("midreset_state", 32'(state_dbg), 32'd0);
    check("midreset_irwrite", 32'(irwrite), 32'd1);
    check("midreset_pcwrite", 32'(pcwrite), 32'd1);
    check("midreset_regwrite", 32'(regwrite), 32'd0);
    check("midreset_memwrite", 32'(memwrite), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    run_word("lw_after_reset", 32'h00402083, 1'b0);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IA;
        4: rop = JL;
        5: rop = BQ;
        default: begin
          rop = 7'($urandom_range(0, 127));
          while (is_legal(rop)) rop = 7'($urandom_range(0, 127));
        end
      endcase
      run_instr($sformatf("rnd%0d", n), rop, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
